// File: rtl/pong_pkg.sv
// Shared constants, state encoding and ball state record for the Pong pixel generator.
package pong_pkg;

  localparam logic [11:0] COL_BALL = 12'hF00;
  localparam logic [11:0] COL_PAD  = 12'h0F0;
  localparam logic [11:0] COL_WALL = 12'h00F;
  localparam logic [11:0] COL_BG   = 12'h000;

  localparam logic [9:0] BALL_X0  = 10'd316;
  localparam logic [9:0] BALL_Y0  = 10'd196;
  localparam logic [9:0] PAD_TOP0 = 10'd168;
  localparam logic [9:0] PAD_MAX  = 10'd336;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    MISS  = 2'd2
  } state_e;

  typedef struct packed {
    logic [9:0] bx;
    logic [9:0] by;
    logic       dx;
    logic       dy;
  } ball_t;

  localparam ball_t BALL_RST = '{bx: BALL_X0, by: BALL_Y0, dx: 1'b1, dy: 1'b1};

  function automatic logic in_span(input logic [10:0] v, input logic [10:0] lo,
                                   input logic [10:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pong_ball_ctrl.sv
// Ball state machine: serve delay, per-frame motion with wall/edge/paddle bounces,
// hit counter and the one-cycle miss pulse.
module pong_ball_ctrl
  import pong_pkg::*;
#(
  parameter int H_DISP       = 640,
  parameter int V_DISP       = 400,
  parameter int WALL_R       = 39,
  parameter int PAD_L        = 600,
  parameter int PAD_H        = 64,
  parameter int BALL_SZ      = 8,
  parameter int BALL_SPD     = 2,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [9:0] pad_top,
  output logic [9:0] bx,
  output logic [9:0] by,
  output logic       miss,
  output logic [7:0] hits
);

  localparam logic [9:0]  SPD10      = 10'(BALL_SPD);
  localparam logic [10:0] SPD11      = 11'(BALL_SPD);
  localparam logic [10:0] SZ11       = 11'(BALL_SZ);
  localparam logic [10:0] PH11       = 11'(PAD_H);
  localparam logic [10:0] Y_BOT_LIM  = 11'(V_DISP - BALL_SZ - BALL_SPD);
  localparam logic [9:0]  Y_BOT      = 10'(V_DISP - BALL_SZ);
  localparam logic [10:0] X_WALL_LIM = 11'(WALL_R + 1 + BALL_SPD);
  localparam logic [9:0]  X_WALL     = 10'(WALL_R + 1);
  localparam logic [10:0] PAD_NEAR   = 11'(PAD_L - BALL_SZ - BALL_SPD);
  localparam logic [10:0] PAD_FAR    = 11'(PAD_L - BALL_SZ);
  localparam logic [9:0]  X_PAD      = 10'(PAD_L - BALL_SZ);
  localparam logic [10:0] X_MISS     = 11'(H_DISP - BALL_SZ);
  localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);

  state_e     state_q, state_d;
  ball_t      ball_q, ball_d, mv;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] hits_q, hits_d;
  logic       pad_hit, x_miss, pad_y_ovl;
  logic [10:0] bx_w, by_w, pad_w;

  assign bx_w  = {1'b0, ball_q.bx};
  assign by_w  = {1'b0, ball_q.by};
  assign pad_w = {1'b0, pad_top};
  assign pad_y_ovl = (by_w + SZ11 > pad_w) && (by_w < pad_w + PH11);

  // Candidate position for one PLAY frame; X and Y resolve independently.
  always_comb begin : ball_move
    mv      = ball_q;
    pad_hit = 1'b0;
    x_miss  = 1'b0;
    if (!ball_q.dy && by_w <= SPD11) begin
      mv.by = '0;
      mv.dy = 1'b1;
    end else if (ball_q.dy && by_w >= Y_BOT_LIM) begin
      mv.by = Y_BOT;
      mv.dy = 1'b0;
    end else begin
      mv.by = ball_q.dy ? ball_q.by + SPD10 : ball_q.by - SPD10;
    end
    if (!ball_q.dx && bx_w <= X_WALL_LIM) begin
      mv.bx = X_WALL;
      mv.dx = 1'b1;
    end else if (ball_q.dx && bx_w >= PAD_NEAR && bx_w <= PAD_FAR && pad_y_ovl) begin
      mv.bx   = X_PAD;
      mv.dx   = 1'b0;
      pad_hit = 1'b1;
    end else begin
      mv.bx  = ball_q.dx ? ball_q.bx + SPD10 : ball_q.bx - SPD10;
      x_miss = ({1'b0, mv.bx} >= X_MISS);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SERVE;
    else        state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      SERVE:   if (frame_tick && frame_cnt_q == SERVE_LAST) state_d = PLAY;
      PLAY:    if (frame_tick && x_miss) state_d = MISS;
      MISS:    state_d = SERVE;
      default: state_d = SERVE;
    endcase
  end

  always_comb begin : datapath
    ball_d      = ball_q;
    frame_cnt_d = frame_cnt_q;
    hits_d      = hits_q;
    unique case (state_q)
      SERVE: if (frame_tick) frame_cnt_d = (frame_cnt_q == SERVE_LAST) ? '0 : frame_cnt_q + 8'd1;
      PLAY: if (frame_tick) begin
        ball_d = mv;
        if (pad_hit)     hits_d = hits_q + 8'd1;
        else if (x_miss) hits_d = '0;
      end
      MISS: begin
        ball_d      = BALL_RST;
        frame_cnt_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ball_q      <= BALL_RST;
      frame_cnt_q <= '0;
      hits_q      <= '0;
    end else begin
      ball_q      <= ball_d;
      frame_cnt_q <= frame_cnt_d;
      hits_q      <= hits_d;
    end
  end

  always_comb begin : outputs
    miss = (state_q == MISS);
    bx   = ball_q.bx;
    by   = ball_q.by;
    hits = hits_q;
  end

endmodule

// File: rtl/pong_pixel_gen.sv
// Pong pixel generator: button sync, frame tick, paddle register and registered rgb mux
// around the ball controller.
module pong_pixel_gen
  import pong_pkg::*;
#(
  parameter int H_DISP       = 640,
  parameter int V_DISP       = 400,
  parameter int WALL_L       = 32,
  parameter int WALL_R       = 39,
  parameter int PAD_L        = 600,
  parameter int PAD_R        = 607,
  parameter int PAD_H        = 64,
  parameter int PAD_STEP     = 4,
  parameter int BALL_SZ      = 8,
  parameter int BALL_SPD     = 2,
  parameter int SERVE_FRAMES = 60
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [11:0] rgb,
  output logic        miss,
  output logic [7:0]  hits
);

  localparam logic [9:0]  Y_FRAME = 10'(V_DISP);
  localparam logic [9:0]  STEP    = 10'(PAD_STEP);
  localparam logic [10:0] WALL_L11 = 11'(WALL_L);
  localparam logic [10:0] WALL_R11 = 11'(WALL_R);
  localparam logic [10:0] PAD_L11  = 11'(PAD_L);
  localparam logic [10:0] PAD_R11  = 11'(PAD_R);
  localparam logic [10:0] BALL_M1  = 11'(BALL_SZ - 1);
  localparam logic [10:0] PAD_HM1  = 11'(PAD_H - 1);

  logic [1:0]  btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
  logic        frame_tick_q, frame_tick_d;
  logic [9:0]  pad_top_q, pad_top_d;
  logic [11:0] rgb_q, rgb_d;
  logic [9:0]  bx, by;
  logic        up_s, dn_s, ball_on, pad_on, wall_on;
  logic [10:0] xw, yw, bxw, byw, pw;

  pong_ball_ctrl #(
    .H_DISP(H_DISP), .V_DISP(V_DISP), .WALL_R(WALL_R), .PAD_L(PAD_L), .PAD_H(PAD_H),
    .BALL_SZ(BALL_SZ), .BALL_SPD(BALL_SPD), .SERVE_FRAMES(SERVE_FRAMES)
  ) u_ball (
    .clk(clk_100MHz), .rst_n(reset_n), .frame_tick(frame_tick_q), .pad_top(pad_top_q),
    .bx(bx), .by(by), .miss(miss), .hits(hits)
  );

  assign up_s = btn_sync_q[1];
  assign dn_s = btn_sync_q[0];
  assign xw   = {1'b0, x};
  assign yw   = {1'b0, y};
  assign bxw  = {1'b0, bx};
  assign byw  = {1'b0, by};
  assign pw   = {1'b0, pad_top_q};

  assign ball_on = in_span(xw, bxw, bxw + BALL_M1) && in_span(yw, byw, byw + BALL_M1);
  assign pad_on  = in_span(xw, PAD_L11, PAD_R11) && in_span(yw, pw, pw + PAD_HM1);
  assign wall_on = in_span(xw, WALL_L11, WALL_R11);

  always_comb begin
    btn_meta_d   = {btn_up, btn_down};
    btn_sync_d   = btn_meta_q;
    // First pixel of the first blanked line: game state moves while nothing is drawn.
    frame_tick_d = p_tick && (x == '0) && (y == Y_FRAME);
    pad_top_d    = pad_top_q;
    if (frame_tick_q) begin
      if (up_s && !dn_s)
        pad_top_d = (pad_top_q >= STEP) ? pad_top_q - STEP : '0;
      else if (dn_s && !up_s)
        pad_top_d = (pad_top_q >= PAD_MAX - STEP) ? PAD_MAX : pad_top_q + STEP;
    end
    rgb_d = rgb_q;
    if (p_tick) begin
      if (!video_on)    rgb_d = COL_BG;
      else if (ball_on) rgb_d = COL_BALL;
      else if (pad_on)  rgb_d = COL_PAD;
      else if (wall_on) rgb_d = COL_WALL;
      else              rgb_d = COL_BG;
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta_q   <= '0;
      btn_sync_q   <= '0;
      frame_tick_q <= 1'b0;
      pad_top_q    <= PAD_TOP0;
      rgb_q        <= '0;
    end else begin
      btn_meta_q   <= btn_meta_d;
      btn_sync_q   <= btn_sync_d;
      frame_tick_q <= frame_tick_d;
      pad_top_q    <= pad_top_d;
      rgb_q        <= rgb_d;
    end
  end

  assign rgb = rgb_q;

endmodule

// File: tb/tb_pong_pixel_gen.sv
// Randomized bench for pong_pixel_gen against a frame-level game model.
module tb_pong_pixel_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p_tick = 1'b0, von = 1'b0, bu = 1'b0, bd = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic [11:0] rgb;
  logic        miss;
  logic [7:0]  hits;

  int n_chk = 0, n_err = 0;
  int m_bx, m_by, m_vx, m_vy, m_pad, m_hits, m_cnt;
  bit m_play, m_missed, track;

  always #5 clk = ~clk;

  pong_pixel_gen dut (
    .clk_100MHz(clk), .reset_n(rst_n), .p_tick(p_tick), .video_on(von),
    .x(x), .y(y), .btn_up(bu), .btn_down(bd), .rgb(rgb), .miss(miss), .hits(hits)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic model_ball_home();
    m_bx = 316; m_by = 196; m_vx = 2; m_vy = 2;
    m_hits = 0; m_cnt = 0; m_play = 0;
  endtask

  // One frame of game rules; the paddle test uses the paddle as it was before this frame.
  task automatic model_frame(input bit up, input bit dn);
    int oby;
    m_missed = 0;
    oby = m_by;
    if (m_play) begin
      if (m_vy < 0 && m_by <= 2) begin m_by = 0; m_vy = 2; end
      else if (m_vy > 0 && m_by + 10 >= 400) begin m_by = 392; m_vy = -2; end
      else m_by += m_vy;
      if (m_vx < 0 && m_bx <= 42) begin m_bx = 40; m_vx = 2; end
      else if (m_vx > 0 && m_bx + 8 <= 600 && m_bx + 10 >= 600 &&
               oby + 8 > m_pad && oby < m_pad + 64) begin
        m_bx = 592; m_vx = -2; m_hits = (m_hits + 1) % 256;
      end else begin
        m_bx += m_vx;
        if (m_bx >= 632) m_missed = 1;
      end
    end else begin
      m_cnt++;
      if (m_cnt == 60) begin m_play = 1; m_cnt = 0; end
    end
    if (up && !dn)      m_pad = (m_pad >= 4) ? m_pad - 4 : 0;
    else if (dn && !up) m_pad = (m_pad + 4 <= 336) ? m_pad + 4 : 336;
  endtask

  function automatic logic [11:0] exp_pix(input int px, input int py, input bit v);
    if (!v) return 12'h000;
    if (px >= m_bx && px < m_bx + 8 && py >= m_by && py < m_by + 8) return 12'hF00;
    if (px >= 600 && px <= 607 && py >= m_pad && py < m_pad + 64) return 12'h0F0;
    if (px >= 32 && px <= 39) return 12'h00F;
    return 12'h000;
  endfunction

  task automatic do_frame(input bit up, input bit dn);
    bu = up; bd = dn;
    repeat (3) @(posedge clk);
    #1 p_tick = 1'b1; x = 10'd0; y = 10'd400; von = 1'b0;
    @(posedge clk); #1 p_tick = 1'b0;
    @(posedge clk); #1;
    model_frame(up, dn);
    if (m_missed) begin
      chk("miss_pulse", miss, 1);
      chk("miss_bx_edge", 32'(dut.u_ball.bx >= 10'd632), 1);
      chk("miss_hits", hits, 0);
      @(posedge clk); #1;
      chk("miss_width", miss, 0);
      model_ball_home();
    end else begin
      chk("no_miss", miss, 0);
    end
    chk("bx", dut.u_ball.bx, m_bx);
    chk("by", dut.u_ball.by, m_by);
    chk("pad_top", dut.pad_top_q, m_pad);
    chk("hits", hits, m_hits);
  endtask

  task automatic probe(input string tag, input int px, input int py, input bit v,
                       input logic [11:0] exp);
    @(posedge clk); #1 p_tick = 1'b1; x = 10'(px); y = 10'(py); von = v;
    @(posedge clk); #1 p_tick = 1'b0;
    chk(tag, rgb, exp);
    x = 10'(px + 1); y = 10'(py + 3); von = ~v;
    @(posedge clk); #1;
    chk("rgb_hold", rgb, exp);
  endtask

  task automatic probe_model(input string tag, input int px, input int py, input bit v);
    if (px < 0) px = 0;
    if (py < 0) py = 0;
    if (px > 639) px = 639;
    if (px == 0 && py == 400) py = 401;
    probe(tag, px, py, v, exp_pix(px, py, v));
  endtask

  initial begin
    bit up, dn;
    int pc, bc;
    model_ball_home();
    m_pad = 168;
    track = 1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", rgb, 0);
    chk("rst_miss", miss, 0);
    chk("rst_hits", hits, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_bx", dut.u_ball.bx, 316);
    chk("rst_by", dut.u_ball.by, 196);
    chk("rst_pad", dut.pad_top_q, 168);

    probe("pix_wall", 35, 10, 1'b1, 12'h00F);
    probe("pix_ball", 320, 200, 1'b1, 12'hF00);
    probe("pix_blank", 320, 200, 1'b0, 12'h000);

    for (int f = 0; f < 50; f++) do_frame(1'b1, 1'b0);
    chk("pad_clamp_top", dut.pad_top_q, 0);
    for (int f = 0; f < 5; f++) do_frame(1'b1, 1'b1);
    for (int f = 0; f < 5; f++) do_frame(1'b0, 1'b0);
    chk("serve_hold_x", dut.u_ball.bx, 316);
    chk("serve_hold_y", dut.u_ball.by, 196);
    do_frame(1'b0, 1'b0);
    chk("first_move_x", dut.u_ball.bx, 318);
    chk("first_move_y", dut.u_ball.by, 198);

    for (int f = 0; f < 1500; f++) begin
      if (!m_play) track = ($urandom_range(0, 3) != 0);
      if (track) begin
        pc = m_pad + 32; bc = m_by + 4;
        up = (pc > bc + 4); dn = (pc < bc - 4);
        if ($urandom_range(0, 15) == 0) begin up = 1; dn = 1; end
      end else begin
        up = 1'($urandom); dn = 1'($urandom);
      end
      do_frame(up, dn);
      probe_model("pix_rand", $urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom_range(0, 7) != 0));
      probe_model("pix_ball_edge", m_bx - 1 + $urandom_range(0, 9), m_by - 1 + $urandom_range(0, 9), 1'b1);
      if (f % 2 == 0)
        probe_model("pix_pad_edge", 599 + $urandom_range(0, 9), m_pad - 1 + $urandom_range(0, 65), 1'b1);
      else
        probe_model("pix_wall_edge", 31 + $urandom_range(0, 9), $urandom_range(0, 399), 1'b1);
    end

    probe_model("pix_pre_rst", m_bx + 2, m_by + 2, 1'b1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rgb", rgb, 0);
    chk("async_rst_miss", miss, 0);
    chk("async_rst_hits", hits, 0);
    chk("async_rst_bx", dut.u_ball.bx, 316);
    chk("async_rst_pad", dut.pad_top_q, 168);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
